// File: rtl/restador_pkg.sv
// Shared types and defaults for the bit-serial subtractor restador_serial.
package restador_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int unsigned N_DEFAULT = 4;

endpackage : restador_pkg

// File: rtl/restador_serial_sumador_completo.sv
// One-bit full adder used as the serial bit cell of restador_serial.
module sumador_completo (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   always_comb begin
      s    = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule : sumador_completo

// File: rtl/restador_serial.sv
// Bit-serial N-bit subtractor (A - B = A + ~B + 1, LSB first) with start/busy/done handshake.
// Optional signed-overflow output enabled by defining RESTADOR_OVF_EN.
module restador_serial
   import restador_pkg::*;
#(
   parameter int unsigned N = N_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         borrow,
   output logic         zero
`ifdef RESTADOR_OVF_EN
   ,
   output logic         ovf
`endif
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   state_t         state_q, state_d;
   logic [N-1:0]   a_sh_q, a_sh_d;
   logic [N-1:0]   b_sh_q, b_sh_d;
   logic           carry_q, carry_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   result_q, result_d;
   logic           borrow_q, borrow_d;
   logic           zero_q, zero_d;
`ifdef RESTADOR_OVF_EN
   logic           ovf_q, ovf_d;
`endif

   logic fa_s;
   logic fa_cout;

   sumador_completo u_bit_cell (
      .a    (a_sh_q[0]),
      .b    (b_sh_q[0]),
      .cin  (carry_q),
      .s    (fa_s),
      .cout (fa_cout)
   );

   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      borrow_d = borrow_q;
      zero_d   = zero_q;
`ifdef RESTADOR_OVF_EN
      ovf_d    = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d  = SHIFT;
               a_sh_d   = a;
               b_sh_d   = ~b;
               carry_d  = 1'b1;
               cnt_d    = '0;
               result_d = '0;
               borrow_d = 1'b0;
               zero_d   = 1'b0;
`ifdef RESTADOR_OVF_EN
               ovf_d    = 1'b0;
`endif
            end
         end
         SHIFT: begin
            a_sh_d   = a_sh_q >> 1;
            b_sh_d   = b_sh_q >> 1;
            carry_d  = fa_cout;
            // Sum bit enters at the MSB; written as shift/OR so N=1 needs no special slice.
            result_d = (result_q >> 1) | (N'(fa_s) << (N - 1));
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               state_d  = DONE;
               borrow_d = ~fa_cout;
               zero_d   = (result_d == '0);
`ifdef RESTADOR_OVF_EN
               // On the MSB step carry_q is the carry into the MSB.
               ovf_d    = carry_q ^ fa_cout;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         borrow_q <= 1'b0;
         zero_q   <= 1'b0;
`ifdef RESTADOR_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         borrow_q <= borrow_d;
         zero_q   <= zero_d;
`ifdef RESTADOR_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   always_comb begin
      busy   = (state_q != IDLE);
      done   = (state_q == DONE);
      result = result_q;
      borrow = borrow_q;
      zero   = zero_q;
`ifdef RESTADOR_OVF_EN
      ovf    = ovf_q;
`endif
   end

endmodule : restador_serial

// File: tb/tb_restador_serial.sv
// Directed self-checking bench for restador_serial with N=4 (ovf checks when RESTADOR_OVF_EN is defined).
module tb_restador_serial;

   localparam int unsigned N = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] result;
   logic         borrow;
   logic         zero;
`ifdef RESTADOR_OVF_EN
   logic         ovf;
`endif

   int n_cmp = 0;
   int n_err = 0;

   restador_serial #(.N(N)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .borrow (borrow),
      .zero   (zero)
`ifdef RESTADOR_OVF_EN
      ,
      .ovf    (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Starts at a negedge with the DUT idle; ends at the negedge after DONE returns to IDLE.
   task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tbv,
                         input logic [N-1:0] er, input logic eb, input logic ez,
                         input logic eo, input string tag);
      int cyc;
      @(negedge clk);
      a = ta;
      b = tbv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a = ~ta;
      b = ~tbv;
      check({tag, "_busy"}, 32'(busy), 32'd1);
      cyc = 0;
      while (done !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_latency"}, 32'(cyc), 32'(N));
      check({tag, "_result"}, 32'(result), 32'(er));
      check({tag, "_borrow"}, 32'(borrow), 32'(eb));
      check({tag, "_zero"}, 32'(zero), 32'(ez));
`ifdef RESTADOR_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
      if (eo === 1'bx) $display("unexpected X expectation in %s", tag);
`endif
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_hold"}, 32'(result), 32'(er));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int ndone;
      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_borrow", 32'(borrow), 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      rst = 1'b0;

      run_op(4'd7,  4'd3, 4'd4,  1'b0, 1'b0, 1'b0, "7m3");
      run_op(4'd3,  4'd7, 4'hC,  1'b1, 1'b0, 1'b0, "3m7");
      run_op(4'd5,  4'd5, 4'd0,  1'b0, 1'b1, 1'b0, "5m5");
      run_op(4'd0,  4'd0, 4'd0,  1'b0, 1'b1, 1'b0, "0m0");
      run_op(4'd0,  4'd1, 4'hF,  1'b1, 1'b0, 1'b0, "0m1");
      run_op(4'hF,  4'd0, 4'hF,  1'b0, 1'b0, 1'b0, "15m0");
      run_op(4'd8,  4'd1, 4'd7,  1'b0, 1'b0, 1'b1, "8m1");
      run_op(4'd6,  4'd2, 4'd4,  1'b0, 1'b0, 1'b0, "6m2");
      run_op(4'd7,  4'd8, 4'hF,  1'b1, 1'b0, 1'b1, "7m8");

      // Start pulsed during SHIFT must be ignored.
      @(negedge clk);
      a = 4'd7;
      b = 4'd3;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      a = 4'd1;
      b = 4'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            ndone++;
            check("ign_result", 32'(result), 32'd4);
         end
      end
      check("ign_done_count", 32'(ndone), 32'd1);
      check("ign_final_result", 32'(result), 32'd4);
      check("ign_final_busy", 32'(busy), 32'd0);

      // Asynchronous reset in the middle of SHIFT.
      @(negedge clk);
      a = 4'd9;
      b = 4'd2;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_result", 32'(result), 32'd0);
      check("arst_borrow", 32'(borrow), 32'd0);
      check("arst_zero", 32'(zero), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done === 1'b1) ndone++;
      end
      check("arst_no_done", 32'(ndone), 32'd0);
      run_op(4'd9, 4'd2, 4'd7, 1'b0, 1'b0, 1'b1, "after_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_restador_serial
